// File: rtl/x_counter_8_bit_pkg.sv
// x_counter_8_bit_pkg: shared types and constants for the sequenced 8-bit counter.
// Rev 1.0
`default_nettype none

package x_counter_8_bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int   CFG_W        = 9;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/x_counter_8_bit_core.sv
// x_counter_8_bit_core: WIDTH-bit counter datapath, clear has priority over enable.
// Rev 1.0
`default_nettype none

module x_counter_8_bit_core #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule

`default_nettype wire

// File: rtl/x_counter_8_bit_ctrl.sv
// x_counter_8_bit_ctrl: sequencing controller (serial config, start/stop/pause, one-shot/reload).
// Rev 1.0
`default_nettype none

module x_counter_8_bit_ctrl
  import x_counter_8_bit_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_PERIOD = 8'd255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_shift,
  input  logic             i_cfg_data,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_pause,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_wrap
);

  localparam int CW = WIDTH + 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cfg_q, cfg_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic             mode_q, mode_d;
  logic             start_q;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             start_edge;
  logic             cnt_clr;
  logic             cnt_en;
  logic             latch_cfg;
  logic [WIDTH-1:0] count;

  assign start_edge = i_start & ~start_q;

  x_counter_8_bit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr),
    .i_en    (cnt_en),
    .o_count (count)
  );

  // Stop outranks start, start outranks pause, pause outranks counting.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    latch_cfg = 1'b0;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (!i_stop && start_edge) begin
          state_d   = ST_RUN;
          latch_cfg = 1'b1;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (count == per_q) begin
          if (mode_q == MODE_RELOAD) begin
            cnt_clr = 1'b1;
            wrap_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (!i_pause) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          cnt_clr = 1'b1;
        end else if (start_edge) begin
          state_d   = ST_RUN;
          cnt_clr   = 1'b1;
          latch_cfg = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // Config only moves while no run is active, so a run always uses its latched copy.
  always_comb begin
    cfg_d  = cfg_q;
    per_d  = per_q;
    mode_d = mode_q;
    if (i_cfg_shift && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      cfg_d = {cfg_q[CW-2:0], i_cfg_data};
    end
    if (latch_cfg) begin
      per_d  = cfg_q[WIDTH-1:0];
      mode_d = cfg_q[WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cfg_q   <= {MODE_ONESHOT, RESET_PERIOD};
      per_q   <= RESET_PERIOD;
      mode_q  <= MODE_ONESHOT;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      start_q <= i_start;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_count = count;
  assign o_busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign o_done  = done_q;
  assign o_wrap  = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_x_counter_8_bit_ctrl.sv
// tb_x_counter_8_bit_ctrl: scoreboard bench for the sequenced 8-bit counter.
// Rev 1.0
`default_nettype none

module tb_x_counter_8_bit_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_shift;
  logic         cfg_data;
  logic         start;
  logic         stop;
  logic         pause;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrap;

  always #5 clk = ~clk;

  x_counter_8_bit_ctrl #(
    .WIDTH        (W),
    .RESET_PERIOD (8'd255)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_shift (cfg_shift),
    .i_cfg_data  (cfg_data),
    .i_start     (start),
    .i_stop      (stop),
    .i_pause     (pause),
    .o_count     (count),
    .o_busy      (busy),
    .o_done      (done),
    .o_wrap      (wrap)
  );

  typedef struct {
    logic [W-1:0] c;
    logic         b;
    logic         d;
    logic         w;
    int           id;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   seq    = 0;

  task automatic compare(input string name, input int id,
                         input logic [W+2:0] act, input logic [W+2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s #%0d actual cnt=%0d busy=%0b done=%0b wrap=%0b required cnt=%0d busy=%0b done=%0b wrap=%0b",
               name, id, act[W+2:3], act[2], act[1], act[0],
               req[W+2:3], req[2], req[1], req[0]);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      compare("cycle", mon_e.id, {count, busy, done, wrap},
              {mon_e.c, mon_e.b, mon_e.d, mon_e.w});
    end
  end

  // Advance one edge with current inputs, then queue the expected post-edge outputs.
  task automatic cyc(input int c, input bit b, input bit d, input bit w);
    exp_t x;
    @(posedge clk);
    #1;
    x.c  = W'(c);
    x.b  = b;
    x.d  = d;
    x.w  = w;
    x.id = seq;
    seq++;
    q.push_back(x);
  endtask

  task automatic shift_cfg(input logic [8:0] v, input int c);
    for (int i = 8; i >= 0; i--) begin
      cfg_shift = 1'b1;
      cfg_data  = v[i];
      cyc(c, 0, 0, 0);
    end
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(0, 1, 0, 0);
    start = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    pause     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare("reset", 0, {count, busy, done, wrap}, {8'd0, 3'b000});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);

    // One-shot, period 4
    shift_cfg(9'b0_0000_0100, 0);
    pulse_start();
    for (int k = 1; k <= 4; k++) cyc(k, 1, 0, 0);
    cyc(4, 0, 1, 0);
    cyc(4, 0, 0, 0);
    cyc(4, 0, 0, 0);

    // Auto-reload, period 2, configured from DONE
    shift_cfg(9'b1_0000_0010, 4);
    pulse_start();
    for (int r = 0; r < 3; r++) begin
      cyc(1, 1, 0, 0);
      cyc(2, 1, 0, 0);
      cyc(0, 1, 0, 1);
    end
    stop = 1'b1;
    cyc(0, 0, 0, 0);
    stop = 1'b0;

    // Pause and stop, period 10
    shift_cfg(9'b0_0000_1010, 0);
    pulse_start();
    for (int k = 1; k <= 5; k++) cyc(k, 1, 0, 0);
    pause = 1'b1;
    repeat (3) cyc(5, 1, 0, 0);
    pause = 1'b0;
    cyc(5, 1, 0, 0);
    cyc(6, 1, 0, 0);
    cyc(7, 1, 0, 0);
    pause = 1'b1;
    stop  = 1'b1;
    cyc(0, 0, 0, 0);
    pause = 1'b0;
    stop  = 1'b0;

    // Config lockout during RUN; start held high through DONE
    start = 1'b1;
    cyc(0, 1, 0, 0);
    for (int i = 8; i >= 0; i--) begin
      cfg_shift = 1'b1;
      cfg_data  = (i < 2);
      cyc(9 - i, 1, 0, 0);
    end
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
    cyc(10, 1, 0, 0);
    cyc(10, 0, 1, 0);
    repeat (3) cyc(10, 0, 0, 0);
    start = 1'b0;
    cyc(10, 0, 0, 0);
    pulse_start();
    for (int k = 1; k <= 10; k++) cyc(k, 1, 0, 0);
    cyc(10, 0, 1, 0);

    // Period 0, one-shot then auto-reload
    stop = 1'b1;
    cyc(0, 0, 0, 0);
    stop = 1'b0;
    shift_cfg(9'b0_0000_0000, 0);
    pulse_start();
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    shift_cfg(9'b1_0000_0000, 0);
    pulse_start();
    repeat (5) cyc(0, 1, 0, 1);
    stop = 1'b1;
    cyc(0, 0, 0, 0);

    // Start edge together with stop in IDLE stays IDLE
    start = 1'b1;
    cyc(0, 0, 0, 0);
    start = 1'b0;
    stop  = 1'b0;
    cyc(0, 0, 0, 0);

    // Asynchronous reset mid-run, then full-length run on the reset period
    shift_cfg(9'b0_0011_0000, 0);
    pulse_start();
    for (int k = 1; k <= 37; k++) cyc(k, 1, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    compare("async_reset", seq, {count, busy, done, wrap}, {8'd0, 3'b000});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulse_start();
    for (int k = 1; k <= 255; k++) cyc(k, 1, 0, 0);
    cyc(255, 0, 1, 0);
    cyc(255, 0, 0, 0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual pending=%0d required pending=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
